// File: rtl/instr_fetch.sv
// Instruction-fetch stage sitting between the program counter and
// instruction memory. Issues one read per PC value, returns the word with a
// one-cycle iready pulse, and keeps a single-entry last-fetch buffer so that
// re-fetching the same address skips memory.
//
// Memory handshake: in FETCH, mem_ren is held high with mem_addr stable.
// mem_ack high on a clock edge completes the read, and mem_rdata is
// captured on that edge. mem_ack in any other state is ignored. iready
// is a one-cycle pulse. There is no back-pressure from the consumer.
module instr_fetch #(
  parameter int unsigned TIMEOUT = 16  // max FETCH cycles without ack (2..255)
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] PCaddr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        invalidate,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  output logic [31:0] instr,
  output logic        iready,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] READY = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  // Last FETCH cycle count that may still accept an ack.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] tag_q, tag_d;
  logic [31:0] instr_reg_q, instr_reg_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  // Next-state and buffer update logic.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    instr_reg_d = instr_reg_q;
    req_addr_d  = req_addr_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (PCaddr[1:0] != 2'b00) begin
          state_d = ERROR;
        end else if (valid_q && (tag_q == PCaddr)) begin
          state_d = READY;
        end else begin
          state_d    = FETCH;
          req_addr_d = PCaddr;
          wait_cnt_d = 8'd0;
        end
      end
      FETCH: begin
        // PCaddr is deliberately not looked at here; req_addr governs.
        if (mem_ack) begin
          instr_reg_d = mem_rdata;
          tag_d       = req_addr_q;
          valid_d     = 1'b1;
          state_d     = READY;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERROR;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      READY:   state_d = IDLE;
      ERROR:   state_d = ERROR;  // sticky until nRST
      default: state_d = IDLE;
    endcase

    // Clearing the buffer overrides a fill on the same edge; a hit already
    // decided from valid_q this cycle still goes through.
    if (invalidate) begin
      valid_d = 1'b0;
    end
  end

  // State and buffer registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      tag_q       <= 32'd0;
      instr_reg_q <= 32'd0;
      req_addr_q  <= 32'd0;
      wait_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      instr_reg_q <= instr_reg_d;
      req_addr_q  <= req_addr_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Outputs decode straight from registers so reset clears them at once.
  assign mem_addr  = req_addr_q;
  assign mem_ren   = (state_q == FETCH);
  assign instr     = instr_reg_q;
  assign iready    = (state_q == READY);
  assign fetch_err = (state_q == ERROR);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a memory driver, a hit driver, an expected-instruction
// queue filled when data is offered and drained on each iready pulse.
module tb_instr_fetch;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        nRST;
  logic [31:0] PCaddr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        invalidate;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic [31:0] instr;
  logic        iready;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  int n_checks;
  int n_pass;

  instr_fetch #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .PCaddr    (PCaddr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .invalidate(invalidate),
    .mem_addr  (mem_addr),
    .mem_ren   (mem_ren),
    .instr     (instr),
    .iready    (iready),
    .fetch_err (fetch_err),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock and sample 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the next expected instruction and compare with the DUT.
  task automatic sb_compare(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, instr, e);
    end
  endtask

  // Miss driver. Entry: DUT idle in the current cycle. Holds ack off for
  // `waits` FETCH cycles, acks on the next one, then checks READY and IDLE.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] data,
                         input int waits, input bit inv_on_ack);
    PCaddr = addr;
    for (int i = 0; i <= waits; i++) begin
      tick();
      chk("miss_ren", {31'd0, mem_ren}, 32'd1);
      chk("miss_addr", mem_addr, addr);
      chk("miss_iready_low", {31'd0, iready}, 32'd0);
      if (i == waits) begin
        mem_ack    = 1'b1;
        mem_rdata  = data;
        invalidate = inv_on_ack;
        exp_q.push_back(data);
      end
    end
    tick();
    mem_ack    = 1'b0;
    mem_rdata  = $urandom;
    invalidate = 1'b0;
    chk("miss_iready", {31'd0, iready}, 32'd1);
    chk("miss_ren_low", {31'd0, mem_ren}, 32'd0);
    sb_compare("miss_instr");
    tick();
    chk("miss_iready_pulse", {31'd0, iready}, 32'd0);
  endtask

  // Hit driver: one IDLE -> READY -> IDLE round trip with no memory access.
  task automatic do_hit(input logic [31:0] data);
    exp_q.push_back(data);
    tick();
    chk("hit_iready", {31'd0, iready}, 32'd1);
    chk("hit_ren", {31'd0, mem_ren}, 32'd0);
    sb_compare("hit_instr");
    tick();
    chk("hit_iready_low", {31'd0, iready}, 32'd0);
    chk("hit_ren_idle", {31'd0, mem_ren}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_ren"}, {31'd0, mem_ren}, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_iready"}, {31'd0, iready}, 32'd0);
    chk({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    nRST       = 1'b0;
    PCaddr     = 32'h40;
    mem_ack    = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    invalidate = 1'b0;

    // 1. Reset with ack high: everything stays zero.
    repeat (3) tick();
    check_all_zero("reset");
    mem_ack = 1'b0;
    nRST    = 1'b1;
    do_miss(32'h40, 32'h00000013, 0, 1'b0);

    // 2. Miss with two wait cycles, ack in the third FETCH cycle.
    do_miss(32'h0, 32'h00500093, 2, 1'b0);

    // 3. Hit, repeated; spurious ack while idle must not matter.
    do_hit(32'h00500093);
    mem_ack = 1'b1;
    do_hit(32'h00500093);
    mem_ack = 1'b0;
    do_hit(32'h00500093);

    // 4. Next address, ack in the first FETCH cycle, then hit on it.
    do_miss(32'h4, 32'hFE000EE3, 0, 1'b0);
    do_hit(32'hFE000EE3);

    // 5a. Invalidate together with a hit: hit honoured, next access misses.
    invalidate = 1'b1;
    exp_q.push_back(32'hFE000EE3);
    tick();
    invalidate = 1'b0;
    chk("inv_hit_iready", {31'd0, iready}, 32'd1);
    chk("inv_hit_ren", {31'd0, mem_ren}, 32'd0);
    sb_compare("inv_hit_instr");
    tick();
    do_miss(32'h4, 32'h11111111, 1, 1'b0);

    // 5b. Invalidate coincident with ack: data delivered, next fetch misses.
    do_miss(32'h8, 32'h22222222, 0, 1'b1);
    do_miss(32'h8, 32'h33333333, 0, 1'b0);

    // Random-data miss/hit round trips on aligned addresses.
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = {$urandom_range(0, 1023), 2'b00};
      d = $urandom;
      do_miss(a, d, $urandom_range(0, 2), 1'b0);
      do_hit(d);
    end

    // 6a. Misaligned PC: sticky error, ack ignored, no iready.
    PCaddr  = 32'h6;
    tick();
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_ren", {31'd0, mem_ren}, 32'd0);
    mem_ack = 1'b1;
    PCaddr  = 32'h8;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mis_err_sticky", {31'd0, fetch_err}, 32'd1);
      chk("mis_iready", {31'd0, iready}, 32'd0);
    end
    mem_ack = 1'b0;

    // Reset clears the error and the buffer.
    nRST = 1'b0;
    #1;
    chk("err_rst_err", {31'd0, fetch_err}, 32'd0);
    check_all_zero("err_rst");
    nRST = 1'b1;

    // Reset in the middle of FETCH: mem_ren drops asynchronously.
    PCaddr = 32'h4;
    tick();
    chk("midfetch_ren", {31'd0, mem_ren}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("midfetch_rst_ren", {31'd0, mem_ren}, 32'd0);
    chk("midfetch_rst_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    nRST = 1'b1;

    // 6b. Timeout: same address again is a miss; no ack ever arrives.
    for (int i = 0; i < int'(TO); i++) begin
      tick();
      chk("to_ren", {31'd0, mem_ren}, 32'd1);
      chk("to_addr", mem_addr, 32'h4);
      chk("to_err_low", {31'd0, fetch_err}, 32'd0);
    end
    tick();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_ren_low", {31'd0, mem_ren}, 32'd0);
    mem_ack = 1'b1;
    repeat (3) tick();
    chk("to_err_sticky", {31'd0, fetch_err}, 32'd1);
    chk("to_iready", {31'd0, iready}, 32'd0);
    mem_ack = 1'b0;

    chk("sb_drained", exp_q.size(), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
